// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the register/mux/ALU datapath control bus: opcodes,
// register indices, one-hot write enables and the sequencer state encoding.
package cpu_ctrl_pkg;

    localparam logic [7:0] OP_ADD = 8'h05;

    localparam logic [4:0] R0  = 5'd0,  R1  = 5'd1,  R2  = 5'd2,  R3  = 5'd3;
    localparam logic [4:0] R4  = 5'd4,  R5  = 5'd5,  R6  = 5'd6,  R7  = 5'd7;
    localparam logic [4:0] R8  = 5'd8,  R9  = 5'd9,  R10 = 5'd10, R11 = 5'd11;
    localparam logic [4:0] R12 = 5'd12, R13 = 5'd13, R14 = 5'd14, R15 = 5'd15;

    localparam logic [15:0] EN_NONE = 16'h0000;
    localparam logic [15:0] EN_R0   = 16'h0001, EN_R1  = 16'h0002, EN_R2  = 16'h0004;
    localparam logic [15:0] EN_R3   = 16'h0008, EN_R4  = 16'h0010, EN_R5  = 16'h0020;
    localparam logic [15:0] EN_R6   = 16'h0040, EN_R7  = 16'h0080, EN_R8  = 16'h0100;
    localparam logic [15:0] EN_R9   = 16'h0200, EN_R10 = 16'h0400, EN_R11 = 16'h0800;
    localparam logic [15:0] EN_R12  = 16'h1000, EN_R13 = 16'h2000, EN_R14 = 16'h4000;
    localparam logic [15:0] EN_R15  = 16'h8000;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StInit0 = 3'd1;
    localparam state_t StInit1 = 3'd2;
    localparam state_t StAdd   = 3'd3;
    localparam state_t StMov01 = 3'd4;
    localparam state_t StMov12 = 3'd5;
    localparam state_t StDone  = 3'd6;

endpackage

// File: rtl/ctrl_word_rom.sv
// Combinational decode of sequencer state into the datapath control word.
module ctrl_word_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0]  state_i,
    output logic [15:0] immediate_o,
    output logic [15:0] enable_o,
    output logic [4:0]  control1_o,
    output logic [4:0]  control2_o,
    output logic        imm_control_o,
    output logic [7:0]  opcode_o,
    output logic        buff_en_o
);

    always_comb begin
        immediate_o   = 16'h0000;
        enable_o      = EN_NONE;
        control1_o    = R0;
        control2_o    = R0;
        imm_control_o = 1'b0;
        opcode_o      = 8'h00;
        buff_en_o     = 1'b0;
        case (state_i)
            StInit0: begin
                // r0 := r0 + 0; relies on the datapath having cleared r0
                enable_o      = EN_R0;
                imm_control_o = 1'b1;
                opcode_o      = OP_ADD;
                buff_en_o     = 1'b1;
            end
            StInit1: begin
                immediate_o   = 16'h0001;
                enable_o      = EN_R1;
                imm_control_o = 1'b1;
                opcode_o      = OP_ADD;
                buff_en_o     = 1'b1;
            end
            StAdd: begin
                enable_o   = EN_R2;
                control2_o = R1;
                opcode_o   = OP_ADD;
                buff_en_o  = 1'b1;
            end
            StMov01: begin
                enable_o      = EN_R0;
                control1_o    = R1;
                imm_control_o = 1'b1;
                opcode_o      = OP_ADD;
                buff_en_o     = 1'b1;
            end
            StMov12: begin
                enable_o      = EN_R1;
                control1_o    = R2;
                imm_control_o = 1'b1;
                opcode_o      = OP_ADD;
                buff_en_o     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fib_ctrl.sv
// Fibonacci sequencing controller driving the datapath control bus.
// Define FIB_CTRL_OVF_STOP_EN to stop the run on the first ALU carry-out.
module fib_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned N_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] n_terms,
    input  logic           alu_carry,
    output logic           busy,
    output logic           done,
    output logic           term_valid,
    output logic [N_W-1:0] term_count,
    output logic           overflow,
    output logic [15:0]    immediate,
    output logic [15:0]    enable,
    output logic [4:0]     control1,
    output logic [4:0]     control2,
    output logic           imm_control,
    output logic [7:0]     opcode,
    output logic           buff_en
);

    state_t         state_q, state_d;
    logic [N_W-1:0] n_q, n_d;
    logic [N_W-1:0] term_count_q, term_count_d;
    logic           overflow_q, overflow_d;

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        term_count_d = term_count_q;
        overflow_d   = overflow_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StInit0;
                    n_d          = n_terms;
                    term_count_d = '0;
                    overflow_d   = 1'b0;
                end
            end
            StInit0: state_d = StInit1;
            StInit1: state_d = (n_q != '0) ? StAdd : StDone;
            StAdd: begin
                term_count_d = term_count_q + N_W'(1);
                state_d      = StMov01;
`ifdef FIB_CTRL_OVF_STOP_EN
                if (alu_carry) begin
                    overflow_d = 1'b1;
                    state_d    = StDone;
                end
`endif
            end
            StMov01: state_d = StMov12;
            StMov12: state_d = (term_count_q < n_q) ? StAdd : StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            n_q          <= '0;
            term_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            term_count_q <= term_count_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef FIB_CTRL_OVF_STOP_EN
    assign overflow = overflow_q;
`else
    // Carry is ignored and terms simply wrap; keep the flag constant low.
    logic unused_carry;
    logic unused_ovf;
    assign unused_carry = alu_carry;
    assign unused_ovf   = overflow_q;
    assign overflow     = 1'b0;
`endif

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign term_valid = (state_q == StAdd);
    assign term_count = term_count_q;

    ctrl_word_rom u_rom (
        .state_i       (state_q),
        .immediate_o   (immediate),
        .enable_o      (enable),
        .control1_o    (control1),
        .control2_o    (control2),
        .imm_control_o (imm_control),
        .opcode_o      (opcode),
        .buff_en_o     (buff_en)
    );

endmodule

// File: tb/tb_fib_ctrl.sv
// Self-checking bench for fib_ctrl with a behavioural 16-register datapath.
module tb_fib_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, alu_carry;
    logic [4:0]  n_terms;
    logic        busy, done, term_valid, overflow, imm_control, buff_en;
    logic [4:0]  term_count, control1, control2;
    logic [15:0] immediate, enable;
    logic [7:0]  opcode;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fib_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n_terms     (n_terms),
        .alu_carry   (alu_carry),
        .busy        (busy),
        .done        (done),
        .term_valid  (term_valid),
        .term_count  (term_count),
        .overflow    (overflow),
        .immediate   (immediate),
        .enable      (enable),
        .control1    (control1),
        .control2    (control2),
        .imm_control (imm_control),
        .opcode      (opcode),
        .buff_en     (buff_en)
    );

    // Reference datapath: register file, two muxes, adder, buffered write-back.
    logic [15:0] rf [16];
    logic [15:0] lhs, rhs;
    logic [16:0] sum;

    always_comb begin
        lhs = rf[control1[3:0]];
        rhs = imm_control ? immediate : rf[control2[3:0]];
        sum = {1'b0, lhs} + {1'b0, rhs};
    end

    assign alu_carry = buff_en && (opcode == 8'h05) && sum[16];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
        end else if (buff_en && opcode == 8'h05) begin
            for (int i = 0; i < 16; i++) if (enable[i]) rf[i] <= sum[15:0];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] all_outs();
        return {3'b0, busy, done, term_valid, term_count, overflow, immediate, enable,
                control1, control2, imm_control, opcode, buff_en};
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1; start = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic start_run(input int n);
        @(posedge clk); #1 start = 1'b1; n_terms = 5'(n);
        @(posedge clk); #1 start = 1'b0;
    endtask

    logic [15:0] r2_seq [$];

    // Watch a run cycle by cycle (k = 1 is the INIT0 cycle) until done or budget expiry.
    task automatic watch(input bit poke, output int done_k, output int tv_cnt,
                         output int idle_cnt);
        bit prev_tv = 1'b0;
        done_k = -1; tv_cnt = 0; idle_cnt = 0;
        r2_seq.delete();
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (prev_tv) r2_seq.push_back(rf[2]);
            prev_tv = term_valid;
            if (term_valid) tv_cnt++;
            if (!busy) idle_cnt++;
            if (poke && k == 10) begin start = 1'b1; n_terms = 5'd3; end
            if (poke && k == 13) start = 1'b0;
            if (done) begin done_k = k; break; end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] imm;
        logic [15:0] en;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        immc;
        logic [7:0]  op;
        logic        buf_en;
        logic        busy;
        logic        done;
        logic        tv;
        logic [4:0]  tc;
    } cyc_vec_t;

    typedef struct {
        int          n;
        int          done_k;
        int          tv_cnt;
        logic [4:0]  tc;
        logic [15:0] r2;
        logic        ovf;
    } run_vec_t;

    cyc_vec_t cyc [7];
    run_vec_t runs [5];

    initial begin
        int dk, tvc, idc;
        logic [15:0] exp5 [5];

        // n = 1 walk: INIT0, INIT1, ADD, MOV01, MOV12, DONE, IDLE
        cyc[0] = '{16'd0, 16'h0001, 5'd0, 5'd0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
        cyc[1] = '{16'd1, 16'h0002, 5'd0, 5'd0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
        cyc[2] = '{16'd0, 16'h0004, 5'd0, 5'd1, 1'b0, 8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
        cyc[3] = '{16'd0, 16'h0001, 5'd1, 5'd0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
        cyc[4] = '{16'd0, 16'h0002, 5'd2, 5'd0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
        cyc[5] = '{16'd0, 16'h0000, 5'd0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1};
        cyc[6] = '{16'd0, 16'h0000, 5'd0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1};

        runs[0] = '{0, 3, 0, 5'd0, 16'd0, 1'b0};
        runs[1] = '{1, 6, 1, 5'd1, 16'd1, 1'b0};
        runs[2] = '{2, 9, 2, 5'd2, 16'd2, 1'b0};
        runs[3] = '{5, 18, 5, 5'd5, 16'd8, 1'b0};
`ifdef FIB_CTRL_OVF_STOP_EN
        runs[4] = '{30, 73, 24, 5'd24, 16'd9489, 1'b1};
`else
        runs[4] = '{30, 93, 30, 5'd30, 16'd35549, 1'b0};
`endif
        exp5 = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd8};

        reset = 1'b1; start = 1'b0; n_terms = 5'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("idle_outs[%0d]", i), all_outs(), 64'd0);
        end

        // Control word walk for n = 1
        do_reset();
        start_run(1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("cw[%0d]", k),
                {immediate, enable, control1, control2, imm_control, opcode, buff_en},
                {cyc[k].imm, cyc[k].en, cyc[k].c1, cyc[k].c2, cyc[k].immc, cyc[k].op,
                 cyc[k].buf_en});
            chk($sformatf("flags[%0d]", k), {busy, done, term_valid, term_count},
                {cyc[k].busy, cyc[k].done, cyc[k].tv, cyc[k].tc});
        end

        // Whole-run table
        for (int r = 0; r < 5; r++) begin
            do_reset();
            start_run(runs[r].n);
            watch(1'b0, dk, tvc, idc);
            chk($sformatf("run%0d_done_k", r), 64'(dk), 64'(runs[r].done_k));
            chk($sformatf("run%0d_tv_cnt", r), 64'(tvc), 64'(runs[r].tv_cnt));
            chk($sformatf("run%0d_busy", r), 64'(idc), 64'd0);
            chk($sformatf("run%0d_tc", r), 64'(term_count), 64'(runs[r].tc));
            chk($sformatf("run%0d_r2", r), 64'(rf[2]), 64'(runs[r].r2));
            chk($sformatf("run%0d_ovf", r), 64'(overflow), 64'(runs[r].ovf));
            if (runs[r].n == 5)
                for (int i = 0; i < 5; i++)
                    chk($sformatf("fib5_r2[%0d]", i),
                        (r2_seq.size() > i) ? 64'(r2_seq[i]) : 64'hdead, 64'(exp5[i]));
            if (runs[r].n == 30)
                chk("term24", (r2_seq.size() > 23) ? 64'(r2_seq[23]) : 64'hdead, 64'd9489);
        end

        // Mid-run start pulse and n_terms change are ignored
        do_reset();
        start_run(10);
        watch(1'b1, dk, tvc, idc);
        chk("poke_done_k", 64'(dk), 64'd33);
        chk("poke_r2", 64'(rf[2]), 64'd89);
        chk("poke_tc", 64'(term_count), 64'd10);
        chk("poke_idle_after", 64'(busy), 64'd0);

        // Reset during the third ADD, then a fresh n = 1 run
        do_reset();
        start_run(5);
        repeat (9) @(negedge clk);
        chk("third_add_tv", {61'd0, term_valid, term_count}, {61'd1, 5'd2});
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_reset_outs", all_outs(), 64'd0);
        reset = 1'b0;
        start_run(1);
        watch(1'b0, dk, tvc, idc);
        chk("rerun_done_k", 64'(dk), 64'd6);
        chk("rerun_r2", 64'(rf[2]), 64'd1);

        // reset and start together: reset wins
        @(negedge clk);
        reset = 1'b1; start = 1'b1; n_terms = 5'd3;
        @(negedge clk);
        chk("reset_vs_start", all_outs(), 64'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset_vs_start_after", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
